// File: rtl/inst_loader.sv
// inst_loader: UART byte-stream program loader driving the instruction BRAM write port.
// Optional trailing checksum byte is enabled by defining INST_LOADER_CHECKSUM_EN.
package utils;
   typedef struct packed {
      logic        wenable;
      logic [31:0] waddr;
      logic [31:0] wdata;
   } bram_wreq_t;
endpackage

module inst_loader #(
   parameter int unsigned MEMSIZE  = 128,
   parameter int unsigned WIDTH    = 32,
   parameter logic [7:0]  ACK_BYTE = 8'hAA,
   parameter logic [7:0]  NAK_BYTE = 8'h55
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output utils::bram_wreq_t mem_wreq,
   output logic              tx_valid,
   output logic [7:0]        tx_data,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [31:0]       words_loaded
);

   localparam logic [31:0] WMASK =
      (WIDTH >= 32) ? 32'hFFFF_FFFF : ((32'd1 << WIDTH) - 32'd1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_DATA,
`ifdef INST_LOADER_CHECKSUM_EN
      S_CSUM,
`endif
      S_FIN
   } state_t;

   state_t      r_state;
   logic [1:0]  r_bcnt;
   logic [31:0] r_len;
   logic [31:0] r_widx;
   logic [31:0] r_word;
   logic [7:0]  r_sum;

   logic [31:0] w_len_full;
   logic [31:0] w_word_full;
   logic        w_last_byte;
   logic        w_last_word;
   logic        w_in_mem;
   logic        w_len_err;
   logic [7:0]  w_sum_next;

   // Both length and data words arrive LSB first, so shift in from the top.
   assign w_len_full  = {rx_data, r_len[31:8]};
   assign w_word_full = {rx_data, r_word[31:8]};
   assign w_last_byte = (r_bcnt == 2'd3);
   assign w_last_word = ((r_widx + 32'd1) == r_len);
   assign w_in_mem    = (r_widx < MEMSIZE);
   assign w_len_err   = (w_len_full > MEMSIZE);
   assign w_sum_next  = r_sum + rx_data;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state      <= S_IDLE;
         r_bcnt       <= 2'd0;
         r_len        <= 32'd0;
         r_widx       <= 32'd0;
         r_word       <= 32'd0;
         r_sum        <= 8'd0;
         mem_wreq     <= '0;
         tx_valid     <= 1'b0;
         tx_data      <= 8'd0;
         busy         <= 1'b0;
         done         <= 1'b0;
         error        <= 1'b0;
         words_loaded <= 32'd0;
      end else begin
         mem_wreq.wenable <= 1'b0;
         tx_valid         <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state      <= S_LEN;
                  r_bcnt       <= 2'd0;
                  r_len        <= 32'd0;
                  r_widx       <= 32'd0;
                  r_sum        <= 8'd0;
                  busy         <= 1'b1;
                  done         <= 1'b0;
                  error        <= 1'b0;
                  words_loaded <= 32'd0;
               end
            end
            S_LEN: begin
               if (rx_valid) begin
                  r_len  <= w_len_full;
                  r_bcnt <= r_bcnt + 2'd1;
                  if (w_last_byte) begin
                     if (w_len_err)
                        error <= 1'b1;
                     if (w_len_full == 32'd0) begin
`ifdef INST_LOADER_CHECKSUM_EN
                        r_state  <= S_CSUM;
`else
                        r_state  <= S_FIN;
                        tx_valid <= 1'b1;
                        tx_data  <= w_len_err ? NAK_BYTE : ACK_BYTE;
`endif
                     end else begin
                        r_state <= S_DATA;
                     end
                  end
               end
            end
            S_DATA: begin
               if (rx_valid) begin
                  r_word <= w_word_full;
                  r_sum  <= w_sum_next;
                  r_bcnt <= r_bcnt + 2'd1;
                  if (w_last_byte) begin
                     r_widx <= r_widx + 32'd1;
                     // Words beyond memory depth are consumed but not written.
                     if (w_in_mem) begin
                        mem_wreq.wenable <= 1'b1;
                        mem_wreq.waddr   <= r_widx;
                        mem_wreq.wdata   <= w_word_full & WMASK;
                        words_loaded     <= words_loaded + 32'd1;
                     end
                     if (w_last_word) begin
`ifdef INST_LOADER_CHECKSUM_EN
                        r_state  <= S_CSUM;
`else
                        r_state  <= S_FIN;
                        tx_valid <= 1'b1;
                        tx_data  <= error ? NAK_BYTE : ACK_BYTE;
`endif
                     end
                  end
               end
            end
`ifdef INST_LOADER_CHECKSUM_EN
            S_CSUM: begin
               if (rx_valid) begin
                  r_state  <= S_FIN;
                  tx_valid <= 1'b1;
                  if (rx_data != r_sum) begin
                     error   <= 1'b1;
                     tx_data <= NAK_BYTE;
                  end else begin
                     tx_data <= error ? NAK_BYTE : ACK_BYTE;
                  end
               end
            end
`endif
            S_FIN: begin
               r_state <= S_IDLE;
               busy    <= 1'b0;
               done    <= 1'b1;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader: table-driven, hand-written and randomized sessions for inst_loader.
// Writes and ack bytes are captured by a monitor and compared with a session model.
module tb_inst_loader;

   localparam int MEMSIZE = 4;

   logic              clk = 1'b0;
   logic              rstn = 1'b0;
   logic              start = 1'b0;
   logic              rx_valid = 1'b0;
   logic [7:0]        rx_data = 8'd0;
   utils::bram_wreq_t mem_wreq;
   logic              tx_valid;
   logic [7:0]        tx_data;
   logic              busy;
   logic              done;
   logic              error;
   logic [31:0]       words_loaded;

   inst_loader #(.MEMSIZE(MEMSIZE)) dut (
      .clk(clk), .rstn(rstn), .start(start),
      .rx_valid(rx_valid), .rx_data(rx_data),
      .mem_wreq(mem_wreq), .tx_valid(tx_valid), .tx_data(tx_data),
      .busy(busy), .done(done), .error(error),
      .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          addr;
      logic [31:0] data;
      int          c;
   } wr_t;

   wr_t         obs_wr[$];
   logic [7:0]  obs_tx[$];

   always @(negedge clk) begin
      if (mem_wreq.wenable)
         obs_wr.push_back('{int'(mem_wreq.waddr), mem_wreq.wdata, cyc});
      if (tx_valid)
         obs_tx.push_back(tx_data);
   end

   int n_tests = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int last_cyc;

   task automatic send_byte(input logic [7:0] b, input int gap);
      for (int g = 0; g < gap; g++) begin
         rx_valid = 1'b0;
         tick();
      end
      rx_valid = 1'b1;
      rx_data  = b;
      last_cyc = cyc;
      tick();
      rx_valid = 1'b0;
   endtask

   logic [31:0] stim_words[$];

   // One full session; expected writes come from the length/word list.
   task automatic run_session(input string tag, input int len,
                              input int maxgap, input bit bad_csum,
                              input bit mid_start, input bit cerr,
                              input int cwl, input logic [7:0] ctx);
      logic [7:0] sum;
      logic [7:0] b;
      int         wc[$];
      int         exp_n;
      sum = 8'd0;
      obs_wr.delete();
      obs_tx.delete();
      rx_valid = 1'b1;
      rx_data  = 8'hFF;
      tick();
      rx_valid = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      check($sformatf("%s busy", tag), {31'd0, busy}, 32'd1);
      for (int k = 0; k < 4; k++)
         send_byte(8'(len >> (8 * k)), $urandom_range(0, maxgap));
      for (int i = 0; i < len; i++) begin
         for (int k = 0; k < 4; k++) begin
            b = 8'(stim_words[i] >> (8 * k));
            if (mid_start && i == 0 && k == 1)
               start = 1'b1;
            send_byte(b, $urandom_range(0, maxgap));
            start = 1'b0;
            sum = sum + b;
            if (k == 3)
               wc.push_back(last_cyc + 1);
         end
      end
`ifdef INST_LOADER_CHECKSUM_EN
      send_byte(bad_csum ? sum + 8'd1 : sum, $urandom_range(0, maxgap));
`endif
      repeat (4) tick();
      exp_n = (len < MEMSIZE) ? len : MEMSIZE;
      check($sformatf("%s nwrites", tag), obs_wr.size(), exp_n);
      for (int i = 0; i < exp_n && i < obs_wr.size(); i++) begin
         check($sformatf("%s w%0d addr", tag, i), obs_wr[i].addr, i);
         check($sformatf("%s w%0d data", tag, i), obs_wr[i].data,
               stim_words[i]);
         check($sformatf("%s w%0d cycle", tag, i), obs_wr[i].c, wc[i]);
      end
      check($sformatf("%s ntx", tag), obs_tx.size(), 1);
      if (obs_tx.size() > 0)
         check($sformatf("%s txbyte", tag), obs_tx[0], ctx);
      check($sformatf("%s done", tag), {31'd0, done}, 32'd1);
      check($sformatf("%s error", tag), {31'd0, error}, {31'd0, cerr});
      check($sformatf("%s busy_end", tag), {31'd0, busy}, 32'd0);
      check($sformatf("%s words_loaded", tag), words_loaded, cwl);
      if (exp_n > 0)
         check($sformatf("%s waddr_hold", tag), mem_wreq.waddr, exp_n - 1);
   endtask

   task automatic check_zero(input string tag);
      check($sformatf("%s wenable", tag), {31'd0, mem_wreq.wenable}, 0);
      check($sformatf("%s waddr", tag), mem_wreq.waddr, 0);
      check($sformatf("%s wdata", tag), mem_wreq.wdata, 0);
      check($sformatf("%s tx_valid", tag), {31'd0, tx_valid}, 0);
      check($sformatf("%s tx_data", tag), {24'd0, tx_data}, 0);
      check($sformatf("%s busy", tag), {31'd0, busy}, 0);
      check($sformatf("%s done", tag), {31'd0, done}, 0);
      check($sformatf("%s error", tag), {31'd0, error}, 0);
      check($sformatf("%s words_loaded", tag), words_loaded, 0);
   endtask

   typedef struct {
      int         len;
      int         maxgap;
      bit         mid;
      bit         err;
      int         wl;
      logic [7:0] tx;
   } vec_t;

   initial begin
      vec_t tbl[5];
      int   len;
      bit   e;
      tbl[0] = '{2, 0, 1'b0, 1'b0, 2, 8'hAA};
      tbl[1] = '{0, 0, 1'b0, 1'b0, 0, 8'hAA};
      tbl[2] = '{5, 0, 1'b0, 1'b1, 4, 8'h55};
      tbl[3] = '{2, 3, 1'b0, 1'b0, 2, 8'hAA};
      tbl[4] = '{4, 1, 1'b1, 1'b0, 4, 8'hAA};

      rstn = 1'b0;
      repeat (3) tick();
      check_zero("reset");
      rstn = 1'b1;
      tick();

      for (int t = 0; t < 5; t++) begin
         stim_words.delete();
         stim_words.push_back(32'h0000_0013);
         stim_words.push_back(32'h0010_0093);
         for (int i = 2; i < tbl[t].len; i++)
            stim_words.push_back($urandom);
         run_session($sformatf("vec%0d", t), tbl[t].len, tbl[t].maxgap,
                     1'b0, tbl[t].mid, tbl[t].err, tbl[t].wl, tbl[t].tx);
      end

      // Abort mid-session: word 0 written, word 1 half received.
      stim_words.delete();
      stim_words.push_back(32'h1122_3344);
      stim_words.push_back(32'h5566_7788);
      stim_words.push_back(32'h99AA_BBCC);
      obs_wr.delete();
      start = 1'b1;
      tick();
      start = 1'b0;
      send_byte(8'd3, 0);
      for (int k = 1; k < 4; k++)
         send_byte(8'd0, 0);
      for (int j = 0; j < 6; j++)
         send_byte(8'(stim_words[j / 4] >> (8 * (j % 4))), 0);
      tick();
      rstn = 1'b0;
      tick();
      check_zero("midreset");
      rstn = 1'b1;
      for (int j = 0; j < 6; j++)
         send_byte(8'(j), 0);
      repeat (3) tick();
      check("midreset nwrites", obs_wr.size(), 1);
      stim_words.delete();
      stim_words.push_back(32'hCAFE_0001);
      stim_words.push_back(32'hCAFE_0002);
      run_session("after_reset", 2, 1, 1'b0, 1'b0, 1'b0, 2, 8'hAA);

`ifdef INST_LOADER_CHECKSUM_EN
      stim_words.delete();
      stim_words.push_back(32'h0403_0201);
      run_session("csum_ok", 1, 0, 1'b0, 1'b0, 1'b0, 1, 8'hAA);
      run_session("csum_bad", 1, 0, 1'b1, 1'b0, 1'b1, 1, 8'h55);
`endif

      for (int r = 0; r < 20; r++) begin
         len = $urandom_range(0, 6);
         stim_words.delete();
         for (int i = 0; i < len; i++)
            stim_words.push_back($urandom);
         e = (len > MEMSIZE);
         run_session($sformatf("rand%0d", r), len, 3, 1'b0,
                     1'($urandom_range(0, 1)), e,
                     (len < MEMSIZE) ? len : MEMSIZE,
                     e ? 8'h55 : 8'hAA);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Program loader that acts as the writer for the instruction memory's BRAM write-request port.
- Consumes a byte stream from the UART receiver: a 4-byte little-endian word count, then that many 32-bit little-endian instruction words.
- Issues one utils::bram_wreq_t write per assembled word, at consecutive word addresses starting from 0.
- On completion, raises done and emits one acknowledge byte toward the UART transmitter.

Parameters:
- MEMSIZE, 128, instruction memory depth in words; writes at word address >= MEMSIZE are suppressed.
- WIDTH, 32, instruction word width; wdata[WIDTH-1:0] is valid, upper bits are zero.
- ACK_BYTE, 8'hAA, byte sent on successful completion.
- NAK_BYTE, 8'h55, byte sent on completion with error.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; begins a load session.
- rx_valid  in  1  rx_data valid this cycle; one byte per asserted cycle; may be asserted every cycle.
- rx_data  in  8  received byte.
- mem_wreq  out  utils::bram_wreq_t  write request to instruction memory; fields wenable, waddr (word address), wdata.
- tx_valid  out  1  one-cycle pulse carrying the ack/nak byte.
- tx_data  out  8  ack/nak byte, valid while tx_valid.
- busy  out  1  session in progress.
- done  out  1  session finished; held until next start or reset.
- error  out  1  session finished with error; held like done.
- words_loaded  out  32  count of words written so far in the current session.

Behaviour:
- Reset (rstn=0 at posedge clk): state IDLE; all outputs 0, mem_wreq all fields 0; byte counter, length and address registers cleared.
- States: IDLE, LEN, DATA, [CSUM], FIN.
- IDLE:
  - start=1 -> LEN; busy=1, done=0, error=0, words_loaded=0.
  - rx_valid is ignored.
- LEN:
  - Collects 4 bytes, first byte = bits [7:0].
  - After the 4th byte: len==0 -> FIN (CSUM if enabled); otherwise -> DATA.
  - len > MEMSIZE sets error=1 but the session continues.
- DATA:
  - Bytes are packed little-endian into a word.
  - On the cycle after the 4th byte of a word is accepted, mem_wreq.wenable=1 for exactly one cycle, with waddr = word index and wdata = assembled word.
  - words_loaded increments in that same cycle.
  - If word index >= MEMSIZE: wenable stays 0 and words_loaded does not increment, but the bytes are still consumed.
  - After the last word's 4th byte -> FIN (CSUM if enabled). The final write and the state change happen together.
- Back-to-back bytes: full throughput of 1 byte/cycle. The write of word n overlaps reception of word n+1; no stall, no ready signal.
- FIN (entered for one cycle):
  - tx_valid=1; tx_data = error ? NAK_BYTE : ACK_BYTE.
  - Next cycle -> IDLE with busy=0, done=1; error held.
- start while busy is ignored.
- rx_valid outside LEN/DATA/CSUM is ignored.
- Reset mid-session: aborts immediately. No further writes are issued, even if a word was pending.
- mem_wreq fields other than wenable hold their last values when wenable=0; they are zero after reset.

Optional Feature:
- Macro: INST_LOADER_CHECKSUM_EN.
- Defined:
  - State CSUM follows DATA (or LEN when len==0) and accepts one byte.
  - This byte is compared with the 8-bit modulo-256 sum of all data bytes; the length bytes are excluded.
  - A mismatch sets error=1. Then -> FIN.
- Undefined:
  - No CSUM state and no checksum byte.
  - error arises only from len > MEMSIZE.

Test Plan:
- start; bytes 02 00 00 00, 13 00 00 00, 93 00 10 00 back-to-back -> wreq (addr 0, data 0x00000013) and (addr 1, data 0x00100093), each one cycle after the word's last byte; tx_data=0xAA; done=1, error=0, words_loaded=2.
- start; length 00 00 00 00 -> no wreq; tx_valid with 0xAA; done=1.
- MEMSIZE=4; length 5, 20 data bytes -> exactly 4 writes (addr 0..3); error=1; tx_data=0x55; words_loaded=4.
- Bytes with rx_valid gaps of 0-3 random idle cycles -> same writes and data as the back-to-back case.
- rstn pulled low after 6 data bytes -> no further wreq; all outputs 0; a fresh start loads correctly from addr 0.
- With INST_LOADER_CHECKSUM_EN: length 1, data 01 02 03 04, checksum 0A -> ack 0xAA; same stimulus with checksum 0B -> error=1, ack 0x55, and the word is still written.
